// File: rtl/fix_pkg.sv
`default_nettype none
// ============================================================================
// Module : fix_pkg
// Brief  : Shared types and helpers for the fixed-point accumulator.
//          - fix_acc_state_e: accumulator FSM state encoding.
//          - fix_acc_max/fix_acc_min: two's-complement saturation rails for
//            an accumulator of a given width. The rails are returned
//            zero-extended in a wide vector. Callers size-cast the result
//            down to their own width.
// Rev    : 1.0 - initial release
// ============================================================================
package fix_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } fix_acc_state_e;

    // Widest accumulator the rail helpers can describe.
    localparam int FIX_RAIL_W = 128;

    // Most negative value: only the sign bit of the target width is set.
    function automatic logic [FIX_RAIL_W-1:0] fix_acc_min(input int unsigned acc_width);
        logic [FIX_RAIL_W-1:0] w_rail;
        w_rail                = '0;
        w_rail[acc_width - 1] = 1'b1;
        return w_rail;
    endfunction

    // Most positive value: all bits below the sign bit are set.
    function automatic logic [FIX_RAIL_W-1:0] fix_acc_max(input int unsigned acc_width);
        return fix_acc_min(acc_width) - FIX_RAIL_W'(1);
    endfunction

endpackage : fix_pkg
`default_nettype wire

// File: rtl/fix_sat_adder.sv
`default_nettype none
// ============================================================================
// Module : fix_sat_adder
// Brief  : Combinational saturating two's-complement adder.
//          The adder works at ACC_WIDTH+1 bits so that the true sum of two
//          ACC_WIDTH operands is always representable. The result is then
//          clamped back to ACC_WIDTH bits.
// Ports  : i_acc   in  ACC_WIDTH  current accumulator value
//          i_term  in  ACC_WIDTH  term, already sign-extended to ACC_WIDTH
//          o_sum   out ACC_WIDTH  clamped sum
//          o_sat   out 1          the sum was clamped to a rail
// Rev    : 1.0 - initial release
// ============================================================================
module fix_sat_adder
    import fix_pkg::*;
#(
    parameter int ACC_WIDTH = 48
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [ACC_WIDTH-1:0] i_term,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_sat
);

    localparam logic [ACC_WIDTH-1:0] c_acc_max = ACC_WIDTH'(fix_acc_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] c_acc_min = ACC_WIDTH'(fix_acc_min(ACC_WIDTH));

    logic [ACC_WIDTH:0] w_sum_ext;

    assign w_sum_ext = {i_acc[ACC_WIDTH-1], i_acc} + {i_term[ACC_WIDTH-1], i_term};

    // The extended sum lies outside the ACC_WIDTH range exactly when its
    // two top bits disagree. The top bit gives the direction of the overflow.
    assign o_sat = w_sum_ext[ACC_WIDTH] ^ w_sum_ext[ACC_WIDTH-1];

    always_comb begin
        o_sum = w_sum_ext[ACC_WIDTH-1:0];
        if (o_sat) begin
            o_sum = w_sum_ext[ACC_WIDTH] ? c_acc_min : c_acc_max;
        end
    end

endmodule : fix_sat_adder
`default_nettype wire

// File: rtl/fix_accumulator.sv
`default_nettype none
// ============================================================================
// Module : fix_accumulator
// Brief  : Packet-wise saturating accumulator for fixed-point terms.
//          The block sums the terms of each packet into a wider
//          accumulator. It presents one result per packet, made of the sum,
//          the term count and a sticky overflow flag. A packet closes on
//          in_last_i or when it reaches MAX_TERMS beats. The result is then
//          held until downstream accepts it.
//          ACC_WIDTH must be at least FIXED_OP_WIDTH+1.
// Ports  : clk_i        in  1               clock, rising edge
//          arst_ni      in  1               async active-low reset
//          in_valid_i   in  1               term valid
//          in_ready_o   out 1               block can take a term
//          in_data_i    in  FIXED_OP_WIDTH  term, two's complement
//          in_last_i    in  1               final term of the packet
//          out_valid_o  out 1               result valid
//          out_ready_i  in  1               downstream takes the result
//          out_sum_o    out ACC_WIDTH       saturated packet sum
//          out_count_o  out CNT_WIDTH       terms in the packet
//          out_ovf_o    out 1               some addition saturated
// Rev    : 1.0 - initial release
// ============================================================================
module fix_accumulator
    import fix_pkg::*;
#(
    parameter int FIXED_OP_WIDTH = 40,
    parameter int ACC_WIDTH      = 48,
    parameter int MAX_TERMS      = 256,
    parameter int CNT_WIDTH      = $clog2(MAX_TERMS) + 1
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [FIXED_OP_WIDTH-1:0] in_data_i,
    input  logic                      in_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ACC_WIDTH-1:0]      out_sum_o,
    output logic [CNT_WIDTH-1:0]      out_count_o,
    output logic                      out_ovf_o
);

    localparam logic [CNT_WIDTH-1:0] c_max_terms = CNT_WIDTH'(MAX_TERMS);

    fix_acc_state_e         r_state;
    fix_acc_state_e         w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_ovf;

    logic [ACC_WIDTH-1:0]   w_term;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic                   w_sat;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic                   w_accept;
    logic                   w_close;
    logic                   w_out_hs;

    assign w_term    = {{(ACC_WIDTH - FIXED_OP_WIDTH){in_data_i[FIXED_OP_WIDTH-1]}}, in_data_i};
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

    // Ready depends only on state, so a source never sees a valid->ready path.
    assign in_ready_o  = (r_state == ACCUM);
    assign out_valid_o = (r_state == HOLD);

    assign w_accept = in_valid_i && in_ready_o;
    assign w_close  = w_accept && (in_last_i || (w_cnt_inc == c_max_terms));
    assign w_out_hs = out_valid_o && out_ready_i;

    fix_sat_adder #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_adder (
        .i_acc  (r_acc),
        .i_term (w_term),
        .o_sum  (w_acc_nxt),
        .o_sat  (w_sat)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_close)  w_state_nxt = HOLD;
            HOLD:    if (w_out_hs) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, term counter and sticky overflow. These registers
    // drive the result ports directly, so they stay frozen in HOLD and
    // clear only when the result is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_out_hs) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_inc;
            if (w_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out_sum_o   = r_acc;
    assign out_count_o = r_cnt;
    assign out_ovf_o   = r_ovf;

endmodule : fix_accumulator
`default_nettype wire

// File: tb/tb_fix_accumulator.sv
`default_nettype none
// ============================================================================
// Module : tb_fix_accumulator
// Brief  : Directed self-checking bench for fix_accumulator.
//          Instance A uses the default parameters (40/48/256). Instance B
//          uses 40/41/4 and exercises saturation and the auto-close on
//          MAX_TERMS. A select bit routes the shared stimulus to one
//          instance and picks its outputs for checking.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fix_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic [39:0] in_data;
    logic        in_last;
    logic        out_ready;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [47:0] a_out_sum;
    logic [8:0]  a_out_count;

    // Instance B: narrow accumulator, four terms max
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [40:0] b_out_sum;
    logic [2:0]  b_out_count;

    fix_accumulator u_dut_a (
        .clk_i       (clk),
        .arst_ni     (rst_n),
        .in_valid_i  (in_valid & ~sel),
        .in_ready_o  (a_in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (a_out_valid),
        .out_ready_i (out_ready & ~sel),
        .out_sum_o   (a_out_sum),
        .out_count_o (a_out_count),
        .out_ovf_o   (a_out_ovf)
    );

    fix_accumulator #(
        .FIXED_OP_WIDTH (40),
        .ACC_WIDTH      (41),
        .MAX_TERMS      (4)
    ) u_dut_b (
        .clk_i       (clk),
        .arst_ni     (rst_n),
        .in_valid_i  (in_valid & sel),
        .in_ready_o  (b_in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (b_out_valid),
        .out_ready_i (out_ready & sel),
        .out_sum_o   (b_out_sum),
        .out_count_o (b_out_count),
        .out_ovf_o   (b_out_ovf)
    );

    logic        obs_ready, obs_valid, obs_ovf;
    logic [47:0] obs_sum;
    logic [8:0]  obs_count;

    assign obs_ready = sel ? b_in_ready  : a_in_ready;
    assign obs_valid = sel ? b_out_valid : a_out_valid;
    assign obs_ovf   = sel ? b_out_ovf   : a_out_ovf;
    assign obs_sum   = sel ? {{7{b_out_sum[40]}}, b_out_sum} : a_out_sum;
    assign obs_count = sel ? {6'd0, b_out_count} : a_out_count;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one beat at a negedge and waits (bounded) for ready.
    // It returns 1 time unit after the edge that accepted the beat.
    task automatic send(input logic [39:0] d, input logic l);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!obs_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!obs_ready) check("send_timeout", 64'(obs_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [47:0] sum,
                                input logic [8:0] cnt, input logic ovf);
        check({tag, "_valid"}, 64'(obs_valid), 64'd1);
        check({tag, "_sum"},   64'(obs_sum),   64'(sum));
        check({tag, "_count"}, 64'(obs_count), 64'(cnt));
        check({tag, "_ovf"},   64'(obs_ovf),   64'(ovf));
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_valid", 64'(a_out_valid), 64'd0);
        check("rst_sum",   64'(a_out_sum),   64'd0);
        check("rst_count", 64'(a_out_count), 64'd0);
        check("rst_ovf",   64'(a_out_ovf),   64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 64'(a_in_ready), 64'd1);

        // +5, -3, +10 -> 12
        out_ready = 1'b1;
        send(40'd5, 1'b0);
        send(40'hFF_FFFF_FFFD, 1'b0);
        send(40'd10, 1'b1);
        check_result("p1", 48'd12, 9'd3, 1'b0);
        check("p1_ready_low", 64'(obs_ready), 64'd0);
        @(posedge clk); #1;
        check("p1_ready_back", 64'(obs_ready), 64'd1);
        check("p1_valid_drop", 64'(obs_valid), 64'd0);

        // Single most-negative term
        send(40'h80_0000_0000, 1'b1);
        check_result("neg", 48'hFF80_0000_0000, 9'd1, 1'b0);
        @(posedge clk); #1;

        // Saturation on B: 3 * (2^39-1) clamps to 2^40-1
        sel = 1'b1;
        send(40'h7F_FFFF_FFFF, 1'b0);
        send(40'h7F_FFFF_FFFF, 1'b0);
        send(40'h7F_FFFF_FFFF, 1'b1);
        check_result("sat", 48'h00FF_FFFF_FFFF, 9'd3, 1'b1);
        @(posedge clk); #1;
        send(40'd1, 1'b1);
        check_result("sat_clr", 48'd1, 9'd1, 1'b0);
        @(posedge clk); #1;

        // Auto-close on B after 4 beats, valid held high, no last
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 40'd1;
        in_last   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_result("max", 48'd4, 9'd4, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            check("max_ready_low", 64'(obs_ready), 64'd0);
            check("max_count_hold", 64'(obs_count), 64'd4);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("max_hs", 64'(obs_valid), 64'd0);

        // Back-pressure on A; a pending beat waits behind the held result
        sel = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        send(40'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 40'd20;
        in_last  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_result("bp", 48'd7, 9'd1, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", 64'(obs_valid), 64'd0);
        check("bp_hs_sum",   64'(obs_sum),   64'd0);
        check("bp_hs_ready", 64'(obs_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 48'd20, 9'd1, 1'b0);
        @(posedge clk); #1;
        check("bp_next_hs", 64'(obs_valid), 64'd0);

        // Reset mid-packet
        send(40'd100, 1'b0);
        send(40'd100, 1'b0);
        check("mid_sum_pre", 64'(obs_sum), 64'd200);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_sum",   64'(obs_sum),   64'd0);
        check("mid_rst_count", 64'(obs_count), 64'd0);
        check("mid_rst_valid", 64'(obs_valid), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(40'd1, 1'b1);
        check_result("post_rst", 48'd1, 9'd1, 1'b0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_fix_accumulator
`default_nettype wire

// File: doc/fix_accumulator.md
Name: fix_accumulator

Overview:
- Downstream consumer of the float-to-fixed converter. Accepts a stream of two's-complement fixed-point terms over a valid/ready handshake.
- Sums the terms of each packet with saturating arithmetic into a wider accumulator.
- Presents one result per packet (sum, term count, overflow flag) on an output valid/ready handshake.
- Used as the reduction stage for dot-product and bias-add paths fed by converted half-precision operands.

Parameters:
- FIXED_OP_WIDTH, 40: width of the input term, two's complement.
- ACC_WIDTH, 48: width of the accumulator and the result. Must be >= FIXED_OP_WIDTH+1.
- MAX_TERMS, 256: maximum number of terms per packet. The packet auto-closes when this is reached.
- CNT_WIDTH, $clog2(MAX_TERMS)+1: width of the term counter and of out_count_o.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- arst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input term valid.
- in_ready_o  out  1  block can accept a term.
- in_data_i  in  FIXED_OP_WIDTH  input term, two's complement.
- in_last_i  in  1  marks the final term of a packet; qualified by the handshake.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_sum_o  out  ACC_WIDTH  saturated packet sum, two's complement.
- out_count_o  out  CNT_WIDTH  number of terms accepted in the packet.
- out_ovf_o  out  1  sticky: at least one addition in the packet saturated.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid_o=0, out_sum_o=0, out_count_o=0, out_ovf_o=0.
  - in_ready_o=1 from the first edge after release.
- Input handshake:
  - A beat is accepted when in_valid_i && in_ready_o on a rising edge.
  - in_ready_o = (state==ACCUM). It is a combinational function of state only and never depends on in_valid_i.
- FSM, two states:
  - ACCUM → HOLD on an accepted beat with in_last_i=1, or on an accepted beat that makes cnt+1==MAX_TERMS (forced close).
  - HOLD → ACCUM when out_valid_o && out_ready_i. On that transition acc, cnt and ovf clear to 0.
- Arithmetic per accepted beat:
  - Sign-extend in_data_i to ACC_WIDTH+1. Add it to acc, also sign-extended to ACC_WIDTH+1.
  - If the result is > 2^(ACC_WIDTH-1)-1, acc takes that maximum value and ovf is set.
  - If the result is < -2^(ACC_WIDTH-1), acc takes that minimum value and ovf is set.
  - Otherwise acc takes the truncated result. ovf is unchanged (sticky within the packet).
  - cnt increments by 1.
- Output:
  - out_valid_o = (state==HOLD). out_sum_o, out_count_o and out_ovf_o are registered and reflect acc, cnt and ovf.
  - Latency: out_valid_o asserts in the cycle after the edge that accepted the closing beat.
  - Outputs hold stable while out_valid_o && !out_ready_i. No new term is accepted in HOLD.
  - Back-to-back packets: after the result handshake edge, in_ready_o=1 in the next cycle. This gives one bubble cycle per packet.
- Boundaries:
  - Simultaneous in_valid_i and out_ready_i in HOLD: only the output handshake occurs; the input beat waits.
  - A single-term packet (in_last_i on the first beat) gives sum = sign-extended term and count=1.
  - A packet can never be empty; a result is produced only after at least one beat.
  - Saturation does not stop accumulation: later terms of the opposite sign move acc back from the rail, and ovf stays 1.
  - Reset asserted mid-packet or in HOLD discards the partial or held result immediately. No output is produced for it.
  - in_data_i and in_last_i are ignored when the beat is not accepted.

Decomposition:
- Package fix_pkg holds:
  - typedef enum logic {ACCUM, HOLD} fix_acc_state_e;
  - a localparam helper for the saturation rails: ACC_MAX/ACC_MIN as functions of ACC_WIDTH.
- One sub-module is natural: fix_sat_adder, a combinational (ACC_WIDTH+1)-bit add with a clamp and an overflow flag, parameterised by ACC_WIDTH.
- The FSM, counter and output registers stay in fix_accumulator.

Test Plan:
- Terms +5, -3, +10 (in_last_i on the 3rd), out_ready_i=1 → one cycle after the 3rd beat: out_valid_o=1, sum=12, count=3, ovf=0. in_ready_o=1 one cycle later.
- Single beat -2^39 with in_last_i → sum=-549755813888 sign-extended to 48 bits, count=1, ovf=0.
- ACC_WIDTH=41, three beats of 2^39-1 with last on the 3rd → sum=2^40-1=1099511627775, ovf=1. Then a packet of +1 with last → sum=1, ovf=0, proving per-packet clear.
- MAX_TERMS=4, in_valid_i held high with in_last_i=0 and data=1 → closes after 4 beats with sum=4, count=4. in_ready_o=0 while out_ready_i=0.
- Packet +7 (last), out_ready_i low for 5 cycles with in_valid_i high → outputs stable at sum=7 for all 5 cycles, no beat accepted. Raise out_ready_i → handshake, and the next packet starts from acc=0.
- Two beats of +100 accepted, then arst_ni pulsed low mid-cycle → all outputs go to 0 immediately. After release, packet +1 (last) → sum=1, count=1.
